// File: rtl/seg7_scan_mux_if.sv
// Front-panel display bus: load strobe with packed hex data toward the
// scanner, multiplexed segment/anode pins and status back from it.
interface seg7_scan_mux_if #(
   parameter int N_DIGITS = 4
);
   logic                    JM1222HM_load;
   logic [4*N_DIGITS-1:0]   JM1222HM_value;
   logic [N_DIGITS-1:0]     JM1222HM_dp;
   logic [N_DIGITS-1:0]     JM1222HM_blank;
   logic [6:0]              JM1222HM_seg_n;
   logic                    JM1222HM_dp_n;
   logic [N_DIGITS-1:0]     JM1222HM_an_n;
   logic                    JM1222HM_busy;
   logic                    JM1222HM_frame;

   modport master (
      output JM1222HM_load, JM1222HM_value, JM1222HM_dp, JM1222HM_blank,
      input  JM1222HM_seg_n, JM1222HM_dp_n, JM1222HM_an_n, JM1222HM_busy,
             JM1222HM_frame
   );

   modport slave (
      input  JM1222HM_load, JM1222HM_value, JM1222HM_dp, JM1222HM_blank,
      output JM1222HM_seg_n, JM1222HM_dp_n, JM1222HM_an_n, JM1222HM_busy,
             JM1222HM_frame
   );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed hex seven-segment driver. A load captures the digits into
// a pending buffer; the pending buffer moves to the displayed buffer only on
// a frame boundary so a frame is never torn. One digit is lit per slot, with
// a short all-anodes-off dead time at the start of each slot.
// Optional macro SEG7_LZ_BLANK_EN: leading-zero suppression, computed at
// commit time and stored alongside the displayed buffer.
module seg7_scan_mux #(
   parameter int N_DIGITS  = 4,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 2
) (
   input  logic           JM1222HM_clk,
   input  logic           JM1222HM_rst_n,
   seg7_scan_mux_if.slave io
);

   localparam int PC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [PC_W-1:0]              pc;
   logic [IDX_W-1:0]             idx;

   logic [N_DIGITS-1:0][3:0]     pend_val;
   logic [N_DIGITS-1:0]          pend_dp;
   logic [N_DIGITS-1:0]          pend_blank;
   logic [N_DIGITS-1:0][3:0]     disp_val;
   logic [N_DIGITS-1:0]          disp_dp;
   logic [N_DIGITS-1:0]          disp_dark;   // blank or suppressed, per digit
   logic                         busy;
   logic                         frame_q;

   logic [6:0]                   seg_q;
   logic                         dp_q;
   logic [N_DIGITS-1:0]          an_q;

   logic                         pc_wrap;
   logic                         boundary;
   logic                         commit;
   logic                         slot_on;
   logic [N_DIGITS-1:0]          lz_mask;
   logic [N_DIGITS-1:0]          an_next;

   assign pc_wrap  = (pc == PC_LAST);
   assign boundary = pc_wrap && (idx == IDX_LAST);
   assign commit   = boundary && busy;

   // Active-low gfedcba pattern for one hex digit.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Dead time: with no blanking cycles the slot is lit from its first cycle.
   generate
      if (BLANK_CYC == 0) begin : g_no_dead
         assign slot_on = 1'b1;
      end else begin : g_dead
         localparam logic [PC_W-1:0] BLANK_PC = PC_W'(BLANK_CYC);
         assign slot_on = (pc >= BLANK_PC);
      end
   endgenerate

`ifdef SEG7_LZ_BLANK_EN
   logic lz_run;

   // Leading-zero mask of the pending buffer, walking down from the top digit;
   // digit 0 is always shown.
   always_comb begin
      lz_run  = 1'b1;
      lz_mask = '0;
      for (int i = N_DIGITS - 1; i >= 1; i--) begin
         lz_run     = lz_run & (pend_val[i] == 4'h0) & ~pend_dp[i];
         lz_mask[i] = lz_run;
      end
   end
`else
   assign lz_mask = '0;
`endif

   // One-hot-low anode for the current digit, all off during dead time.
   always_comb begin
      an_next = '1;
      if (slot_on) an_next[idx] = 1'b0;
   end

   // Scan counters plus load/commit of the double buffer.
   always_ff @(posedge JM1222HM_clk) begin
      if (!JM1222HM_rst_n) begin
         pc         <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_blank <= '1;
         disp_val   <= '0;
         disp_dp    <= '0;
         disp_dark  <= '1;
         busy       <= 1'b0;
         frame_q    <= 1'b0;
      end else begin
         if (pc_wrap) begin
            pc  <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            pc  <= pc + 1'b1;
         end

         frame_q <= commit;
         if (commit) begin
            disp_val  <= pend_val;
            disp_dp   <= pend_dp;
            disp_dark <= pend_blank | lz_mask;
         end

         // A load on the commit cycle keeps busy set for the next frame.
         if (io.JM1222HM_load) begin
            pend_val   <= io.JM1222HM_value;
            pend_dp    <= io.JM1222HM_dp;
            pend_blank <= io.JM1222HM_blank;
            busy       <= 1'b1;
         end else if (commit) begin
            busy       <= 1'b0;
         end
      end
   end

   // Registered pin drive from the current digit of the displayed buffer.
   always_ff @(posedge JM1222HM_clk) begin
      if (!JM1222HM_rst_n) begin
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         an_q  <= '1;
      end else begin
         if (disp_dark[idx]) begin
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
         end else begin
            seg_q <= hex_to_seg(disp_val[idx]);
            dp_q  <= ~disp_dp[idx];
         end
         an_q <= an_next;
      end
   end

   assign io.JM1222HM_seg_n = seg_q;
   assign io.JM1222HM_dp_n  = dp_q;
   assign io.JM1222HM_an_n  = an_q;
   assign io.JM1222HM_busy  = busy;
   assign io.JM1222HM_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
// cyc counts clock edges since reset release; slot/digit expectations are
// derived from it, and the expected displayed digits are set by hand at each
// commit edge.
module tb_seg7_scan_mux;

   logic clk = 1'b0;
   logic rst_n;

   int   cyc;
   int   frame_at;
   int   vectors;
   int   miscompares;
   logic [6:0] exp_seg [4];
   logic       exp_dpn [4];

   seg7_scan_mux_if #(.N_DIGITS(4)) bus ();

   seg7_scan_mux #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
      .JM1222HM_clk   (clk),
      .JM1222HM_rst_n (rst_n),
      .io             (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s (cyc %0d): observed %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic set_exp(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpn);
      exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
      for (int i = 0; i < 4; i++) exp_dpn[i] = dpn[i];
   endtask

   // One clock; checks anode scan, lit digit contents and frame strobe.
   task automatic tick();
      int ph, d;
      logic [3:0] ea;
      @(posedge clk); #1;
      cyc++;
      ph = (cyc - 1) % 4;
      d  = ((cyc - 1) / 4) % 4;
      ea = 4'hF;
      if (ph >= 1) ea[d] = 1'b0;
      chk("an_n", 32'(bus.JM1222HM_an_n), 32'(ea));
      if (ph >= 1) begin
         chk("seg_n", 32'(bus.JM1222HM_seg_n), 32'(exp_seg[d]));
         chk("dp_n", 32'(bus.JM1222HM_dp_n), 32'(exp_dpn[d]));
      end
      chk("frame", 32'(bus.JM1222HM_frame), 32'(cyc == frame_at));
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      bus.JM1222HM_load  = 1'b1;
      bus.JM1222HM_value = v;
      bus.JM1222HM_dp    = d;
      bus.JM1222HM_blank = b;
      tick();
      bus.JM1222HM_load  = 1'b0;
   endtask

   task automatic chk_reset_pins();
      chk("rst_seg_n", 32'(bus.JM1222HM_seg_n), 32'h7F);
      chk("rst_dp_n",  32'(bus.JM1222HM_dp_n),  32'h1);
      chk("rst_an_n",  32'(bus.JM1222HM_an_n),  32'hF);
      chk("rst_busy",  32'(bus.JM1222HM_busy),  32'h0);
      chk("rst_frame", 32'(bus.JM1222HM_frame), 32'h0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; frame_at = -1;
      rst_n = 1'b0;
      bus.JM1222HM_load  = 1'b0;
      bus.JM1222HM_value = '0;
      bus.JM1222HM_dp    = '0;
      bus.JM1222HM_blank = '0;
      set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);

      // Reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_reset_pins();
      rst_n = 1'b1;

      // 1: idle scan, everything dark, no frame
      while (cyc < 40) tick();
      chk("idle_busy", 32'(bus.JM1222HM_busy), 32'h0);

      // 2: single load commits at the next boundary (edge 48)
      do_load(16'h12AF, 4'h0, 4'h0);
      chk("load_busy", 32'(bus.JM1222HM_busy), 32'h1);
      frame_at = 48;
      while (cyc < 47) tick();
      chk("pre_commit_busy", 32'(bus.JM1222HM_busy), 32'h1);
      tick();
      chk("post_commit_busy", 32'(bus.JM1222HM_busy), 32'h0);
      set_exp(7'h0E, 7'h08, 7'h24, 7'h79, 4'hF);
      while (cyc < 64) tick();

      // 3: two loads before one boundary, last wins, single commit at 80
      while (cyc < 65) tick();
      do_load(16'h0001, 4'h0, 4'h0);
      while (cyc < 69) tick();
      do_load(16'h0002, 4'h0, 4'h0);
      chk("reload_busy", 32'(bus.JM1222HM_busy), 32'h1);
      frame_at = 80;
      while (cyc < 80) tick();
      chk("reload_commit_busy", 32'(bus.JM1222HM_busy), 32'h0);
      set_exp(7'h24, 7'h40, 7'h40, 7'h40, 4'hF);
      while (cyc < 89) tick();

      // 4: load exactly on the boundary edge 96
      do_load(16'h3456, 4'h0, 4'h0);
      while (cyc < 95) tick();
      frame_at = 96;
      do_load(16'h789A, 4'b0001, 4'b1000);
      chk("boundary_load_busy", 32'(bus.JM1222HM_busy), 32'h1);
      set_exp(7'h02, 7'h12, 7'h19, 7'h30, 4'hF);
      frame_at = 112;
      while (cyc < 112) tick();
      chk("second_commit_busy", 32'(bus.JM1222HM_busy), 32'h0);
      set_exp(7'h08, 7'h10, 7'h00, 7'h7F, 4'b1110);
      while (cyc < 113) tick();

      // 5: leading zeros with a decimal point on digit 2
      do_load(16'h0070, 4'b0100, 4'h0);
      frame_at = 128;
      while (cyc < 128) tick();
`ifdef SEG7_LZ_BLANK_EN
      set_exp(7'h40, 7'h78, 7'h40, 7'h7F, 4'b1011);
`else
      set_exp(7'h40, 7'h78, 7'h40, 7'h40, 4'b1011);
`endif
      while (cyc < 145) tick();

      // 6: reset mid-slot after a load discards the pending data
      do_load(16'hFFFF, 4'hF, 4'h0);
      while (cyc < 150) tick();
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_pins();
      rst_n = 1'b1;
      cyc = 0;
      frame_at = -1;
      set_exp(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
      while (cyc < 20) tick();
      chk("post_reset_busy", 32'(bus.JM1222HM_busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
